fpa_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational float add/mult unit.
- Supports configurable exponent and mantissa widths.
- Modes: add, subtract and multiply, with round-to-nearest-even and IEEE-style exception flags.
- Sits between an operand-issuing sequencer and a result consumer; uses valid/ready handshakes on both sides and carries a user tag through unchanged.

---
 rtl/fpa_pipe.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fpa_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fpa_pipe.sv
// fpa_pipe: 3-stage pipelined float add/sub/mul, RNE rounding, subnormals flushed to zero.
// Define FPA_FLAGS_EN to build and register out_flags; otherwise out_flags is tied to zero.
module fpa_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [1:0]           in_op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned EW  = EXP_W + 2;
    localparam int unsigned MW  = MAN_W + 1;  // hidden bit + fraction
    localparam int unsigned XW  = MAN_W + 4;  // hidden bit, fraction, guard, round, sticky
    localparam int unsigned PW  = 2 * MW;
    localparam int unsigned RW  = MW + 1;
    localparam int unsigned LZW = $clog2(XW + 1);
    localparam logic [EXP_W-1:0]     EMAX    = '1;
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_TOP = EW'(EMAX);
    localparam logic [W-1:0]         QNAN    = {1'b0, EMAX, 1'b1, {(MAN_W - 1){1'b0}}};

    logic advance;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: unpack, classify, align or multiply ----------------
    logic                 sa, sb, op_sub, op_mul, a_big;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0]     ea, eb, ex, ey, diff;
    logic [MAN_W-1:0]     fa, fb;
    logic [MW-1:0]        ma, mb, mx, my;
    logic [2*XW-1:0]      align_sh;
    logic [XW-1:0]        my_al;
    logic [PW-1:0]        prod;
    logic signed [EW-1:0] s1_exp_d;
    logic                 s1_sign_d, special_d;
    logic [W-1:0]         spec_val_d;

    always_comb begin
        op_sub = (in_op == 2'b01);
        op_mul = (in_op == 2'b10);
        sa     = in_a[W-1];
        sb     = in_b[W-1] ^ op_sub;
        ea     = in_a[W-2 -: EXP_W];
        eb     = in_b[W-2 -: EXP_W];
        fa     = in_a[MAN_W-1:0];
        fb     = in_b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EMAX) && (fa == '0);
        b_inf  = (eb == EMAX) && (fb == '0);
        a_nan  = (ea == EMAX) && (fa != '0);
        b_nan  = (eb == EMAX) && (fb != '0);
        ma     = a_zero ? '0 : {1'b1, fa};
        mb     = b_zero ? '0 : {1'b1, fb};

        a_big    = {ea, ma} >= {eb, mb};
        ex       = a_big ? ea : eb;
        ey       = a_big ? eb : ea;
        mx       = a_big ? ma : mb;
        my       = a_big ? mb : ma;
        diff     = ex - ey;
        align_sh = {my, 3'b000, {XW{1'b0}}} >> diff;
        if (32'(diff) >= MAN_W + 3) begin
            my_al = {{(XW - 1){1'b0}}, |my};
        end else begin
            my_al = align_sh[2*XW-1:XW] | {{(XW - 1){1'b0}}, |align_sh[XW-1:0]};
        end

        prod = PW'(ma) * PW'(mb);
        if (op_mul) begin
            s1_sign_d = sa ^ sb;
            s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        end else begin
            s1_sign_d = a_big ? sa : sb;
            s1_exp_d  = $signed({2'b00, ex});
        end

        special_d  = 1'b0;
        spec_val_d = '0;
        if (a_nan || b_nan) begin
            special_d  = 1'b1;
            spec_val_d = QNAN;
        end else if (op_mul) begin
            if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                special_d  = 1'b1;
                spec_val_d = QNAN;
            end else if (a_inf || b_inf) begin
                special_d  = 1'b1;
                spec_val_d = {sa ^ sb, EMAX, {MAN_W{1'b0}}};
            end else if (a_zero || b_zero) begin
                special_d  = 1'b1;
                spec_val_d = {sa ^ sb, {(W - 1){1'b0}}};
            end
        end else if (a_inf || b_inf) begin
            special_d = 1'b1;
            if (a_inf && b_inf && (sa != sb)) spec_val_d = QNAN;
            else if (a_inf)                   spec_val_d = {sa, EMAX, {MAN_W{1'b0}}};
            else                              spec_val_d = {sb, EMAX, {MAN_W{1'b0}}};
        end
    end

    logic                 s1_valid_q, s1_mul_q, s1_special_q, s1_sign_q, s1_sub_q;
    logic [TAG_W-1:0]     s1_tag_q;
    logic [W-1:0]         s1_spec_val_q;
    logic signed [EW-1:0] s1_exp_q;
    logic [XW-1:0]        s1_mx_q, s1_my_q;
    logic [PW-1:0]        s1_prod_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_mul_q      <= 1'b0;
            s1_special_q  <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_tag_q      <= '0;
            s1_spec_val_q <= '0;
            s1_exp_q      <= '0;
            s1_mx_q       <= '0;
            s1_my_q       <= '0;
            s1_prod_q     <= '0;
        end else if (advance) begin
            s1_valid_q    <= in_valid;
            s1_mul_q      <= op_mul;
            s1_special_q  <= special_d;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= sa ^ sb;
            s1_tag_q      <= in_tag;
            s1_spec_val_q <= spec_val_d;
            s1_exp_q      <= s1_exp_d;
            s1_mx_q       <= {mx, 3'b000};
            s1_my_q       <= my_al;
            s1_prod_q     <= prod;
        end
    end

    // ---------------- S2: add/subtract and normalise ----------------
    logic [XW:0]          sum;
    logic [LZW-1:0]       lz;
    logic [PW-1:0]        prod_n;
    logic                 s2_sign_d, s2_zero_d;
    logic signed [EW-1:0] s2_exp_d;
    logic [XW-1:0]        s2_mant_d;

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                       : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});
        lz = LZW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (sum[i]) lz = LZW'(XW - 1 - i);
        end
        prod_n    = s1_prod_q[PW-1] ? s1_prod_q : (s1_prod_q << 1);
        s2_sign_d = s1_sign_q;
        s2_zero_d = 1'b0;
        if (s1_mul_q) begin
            s2_exp_d  = s1_exp_q + EW'(s1_prod_q[PW-1]);
            s2_mant_d = {prod_n[PW-1 -: XW-1], |prod_n[PW-XW:0]};
        end else if (sum[XW]) begin
            s2_exp_d  = s1_exp_q + EW'(1);
            s2_mant_d = {sum[XW:2], |sum[1:0]};
        end else begin
            s2_exp_d  = s1_exp_q - EW'(lz);
            s2_mant_d = sum[XW-1:0] << lz;
            s2_zero_d = (sum == '0);
            // Exact zero is +0 unless both addends were -0
            if (s2_zero_d) s2_sign_d = s1_sign_q & !s1_sub_q;
        end
    end

    logic                 s2_valid_q, s2_special_q, s2_sign_q, s2_zero_q;
    logic [TAG_W-1:0]     s2_tag_q;
    logic [W-1:0]         s2_spec_val_q;
    logic signed [EW-1:0] s2_exp_q;
    logic [XW-1:0]        s2_mant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q    <= 1'b0;
            s2_special_q  <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_zero_q     <= 1'b0;
            s2_tag_q      <= '0;
            s2_spec_val_q <= '0;
            s2_exp_q      <= '0;
            s2_mant_q     <= '0;
        end else if (advance) begin
            s2_valid_q    <= s1_valid_q;
            s2_special_q  <= s1_special_q;
            s2_sign_q     <= s2_sign_d;
            s2_zero_q     <= s2_zero_d;
            s2_tag_q      <= s1_tag_q;
            s2_spec_val_q <= s1_spec_val_q;
            s2_exp_q      <= s2_exp_d;
            s2_mant_q     <= s2_mant_d;
        end
    end

    // ---------------- S3: round and pack ----------------
    logic                 rnd_up;
    logic [RW-1:0]        rounded;
    logic signed [EW-1:0] r_exp;
    logic [MAN_W-1:0]     r_frac;
    logic [W-1:0]         res_d;

    always_comb begin
        rnd_up  = s2_mant_q[2] & (s2_mant_q[3] | s2_mant_q[1] | s2_mant_q[0]);
        rounded = {1'b0, s2_mant_q[XW-1:3]} + RW'(rnd_up);
        r_exp   = s2_exp_q + EW'(rounded[MW]);
        r_frac  = rounded[MW] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        res_d   = {s2_sign_q, r_exp[EXP_W-1:0], r_frac};
        if (s2_special_q) begin
            res_d = s2_spec_val_q;
        end else if (s2_zero_q || (r_exp <= 0)) begin
            res_d = {s2_sign_q, {(W - 1){1'b0}}};
        end else if (r_exp >= EXP_TOP) begin
            res_d = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (advance) begin
            out_valid  <= s2_valid_q;
            out_result <= res_d;
            out_tag    <= s2_tag_q;
        end
    end

`ifdef FPA_FLAGS_EN
    logic       spec_inv_d, s1_inv_q, s2_inv_q;
    logic [3:0] flg_d;

    always_comb begin
        spec_inv_d = (a_nan & !fa[MAN_W-1]) | (b_nan & !fb[MAN_W-1]);
        if (!a_nan && !b_nan) begin
            spec_inv_d = op_mul ? ((a_inf & b_zero) | (b_inf & a_zero))
                                : (a_inf & b_inf & (sa != sb));
        end
    end

    always_comb begin
        if (s2_special_q)        flg_d = {s2_inv_q, 3'b000};
        else if (s2_zero_q)      flg_d = 4'b0000;
        else if (r_exp <= 0)     flg_d = 4'b0011;
        else if (r_exp >= EXP_TOP) flg_d = 4'b0101;
        else                     flg_d = {3'b000, |s2_mant_q[2:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_inv_q  <= 1'b0;
            s2_inv_q  <= 1'b0;
            out_flags <= 4'b0000;
        end else if (advance) begin
            s1_inv_q  <= spec_inv_d;
            s2_inv_q  <= s1_inv_q;
            out_flags <= flg_d;
        end
    end
`else
    assign out_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fpa_pipe.sv
// Directed bench for fpa_pipe (binary32 configuration): arithmetic, specials, stall and reset.
module tb_fpa_pipe;
    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [1:0]  in_op;
    logic [3:0]  in_tag, out_tag, out_flags;

    int n_tests = 0;
    int n_fail  = 0;
    int issued, got;
    logic [31:0] vals [4];

    fpa_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ef(input logic [3:0] f);
`ifdef FPA_FLAGS_EN
        return f;
`else
        return 4'b0000 & f;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one op into an empty pipe and check it appears exactly 3 cycles later.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [3:0] tag,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({name, ".early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".res"}, out_result, exp_res);
        check({name, ".tag"}, 32'(out_tag), 32'(tag));
        check({name, ".flags"}, 32'(out_flags), 32'(ef(exp_flg)));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1;
        vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
        vals[2] = 32'h40400000; vals[3] = 32'h40800000;
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.res", out_result, 32'd0);
        check("rst.tag", 32'(out_tag), 32'd0);
        check("rst.flags", 32'(out_flags), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        run_op("add", 32'h3FC00000, 32'h40100000, 2'b00, 4'd5, 32'h40700000, 4'b0000);
        run_op("mul", 32'h40400000, 32'hC0000000, 2'b10, 4'd6, 32'hC0C00000, 4'b0000);
        run_op("sub_zero", 32'h40400000, 32'h40400000, 2'b01, 4'd7, 32'h00000000, 4'b0000);
        run_op("inf_m_inf", 32'h7F800000, 32'hFF800000, 2'b00, 4'd1, 32'h7FC00000, 4'b1000);
        run_op("inf_x_0", 32'h7F800000, 32'h00000000, 2'b10, 4'd2, 32'h7FC00000, 4'b1000);
        run_op("ovf", 32'h7F7FFFFF, 32'h40000000, 2'b10, 4'd3, 32'h7F800000, 4'b0101);
        run_op("unf", 32'h00800000, 32'h3F000000, 2'b10, 4'd4, 32'h00000000, 4'b0011);
        run_op("tie_even", 32'h3F800000, 32'h33800000, 2'b00, 4'd8, 32'h3F800000, 4'b0001);
        run_op("tie_odd", 32'h3F800001, 32'h33800000, 2'b00, 4'd9, 32'h3F800002, 4'b0001);
        run_op("op11_add", 32'h3FC00000, 32'h40100000, 2'b11, 4'd10, 32'h40700000, 4'b0000);
        run_op("snan", 32'h7F800001, 32'h3F800000, 2'b00, 4'd11, 32'h7FC00000, 4'b1000);
        run_op("qnan", 32'h3F800000, 32'h7FC00001, 2'b10, 4'd12, 32'h7FC00000, 4'b0000);
        run_op("neg_zeros", 32'h80000000, 32'h80000000, 2'b00, 4'd13, 32'h80000000, 4'b0000);
        run_op("inf_prop", 32'hFF800000, 32'h40000000, 2'b10, 4'd14, 32'hFF800000, 4'b0000);

        // Four back-to-back ops with the consumer stalled for five cycles.
        issued = 0; got = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (issued < 4);
            if (issued < 4) begin
                in_a = vals[issued]; in_b = 32'h00000000; in_op = 2'b00; in_tag = 4'(issued);
            end
            #1;
            if (cyc == 3) begin
                check("stall.in_ready", 32'(in_ready), 32'd0);
                check("stall.valid", 32'(out_valid), 32'd1);
            end
            if (cyc == 4) begin
                check("hold.tag", 32'(out_tag), 32'd0);
                check("hold.res", out_result, vals[0]);
            end
            if (out_valid && out_ready) begin
                if (got < 4) begin
                    check("order.tag", 32'(out_tag), 32'(got));
                    check("order.res", out_result, vals[got]);
                end
                got++;
            end
            if (in_valid && in_ready) issued++;
        end
        in_valid = 1'b0;
        check("stall.issued", 32'(issued), 32'd4);
        check("stall.got", 32'(got), 32'd4);

        // Reset in the middle of a stream discards in-flight work.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = vals[i]; in_b = 32'h0; in_op = 2'b00; in_tag = 4'(8 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst.valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid.valid", 32'(out_valid), 32'd0);
        check("rst_mid.tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        check("rst_mid.valid2", 32'(out_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush.valid", 32'(out_valid), 32'd0);
        end
        run_op("post_rst", 32'h40400000, 32'hC0000000, 2'b10, 4'd15, 32'hC0C00000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
